// File: rtl/arm_inst_encoder.sv
// Symbolic instruction request -> 32-bit ARM word encoder with a small output FIFO.
// Each buffered word carries the instruction-memory word address it was assigned on entry.
module arm_inst_encoder #(
    parameter int         DEPTH  = 2,
    parameter int         ADDR_W = 8,
    parameter logic [3:0] COND   = 4'b1110
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op_sel,
    input  logic [3:0]               rd,
    input  logic [3:0]               rn,
    input  logic [3:0]               rm,
    input  logic [4:0]               shamt,
    input  logic [1:0]               sh,
    input  logic [11:0]              imm12,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDR = 3'd6;
    localparam logic [2:0] OP_STR = 3'd7;

    // Word layout matches the core's decoder: I=0 always, memory ops use
    // pre-indexed positive immediate offsets with no writeback.
    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [3:0]  f_rd,
        input logic [3:0]  f_rn,
        input logic [3:0]  f_rm,
        input logic [4:0]  f_shamt,
        input logic [1:0]  f_sh,
        input logic [11:0] f_imm
    );
        logic [3:0]  cmd;
        logic        s_bit;
        logic [3:0]  rn_f;
        logic [3:0]  rd_f;
        logic [31:0] word;
        cmd   = 4'b0000;
        s_bit = 1'b0;
        rn_f  = f_rn;
        rd_f  = f_rd;
        case (op)
            OP_ADD:  cmd = 4'b0100;
            OP_SUB:  cmd = 4'b0010;
            OP_AND:  cmd = 4'b0000;
            OP_ORR:  cmd = 4'b1100;
            OP_CMP: begin
                cmd   = 4'b1010;
                s_bit = 1'b1;
                rd_f  = 4'd0;
            end
            OP_MOV: begin
                cmd  = 4'b1101;
                rn_f = 4'd0;
            end
            default: cmd = 4'b0000;
        endcase
        if (op == OP_LDR || op == OP_STR) begin
            word = {COND, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    (op == OP_LDR), f_rn, f_rd, f_imm};
        end else begin
            word = {COND, 2'b00, 1'b0, cmd, s_bit, rn_f, rd_f,
                    f_shamt, f_sh, 1'b0, f_rm};
        end
        return word;
    endfunction

    logic [31:0]       fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       last_inst;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       wdata;
    logic              push;
    logic              pop;

    assign wdata     = encode(op_sel, rd, rn, rm, shamt, sh, imm12);
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // When empty the outputs fall back to the most recently popped word.
    assign out_inst  = out_valid ? fifo_inst[rd_ptr] : last_inst;
    assign out_addr  = out_valid ? fifo_addr[rd_ptr] : last_addr;

    // Encode/write stage: storage needs no reset, occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= wdata;
            fifo_addr[wr_ptr] <= wr_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_addr   <= '0;
            last_inst <= '0;
            last_addr <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_addr <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                wr_addr <= wr_addr + 1'b1;
            end
            if (pop) begin
                last_inst <= fifo_inst[rd_ptr];
                last_addr <= fifo_addr[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_inst_encoder.sv
// Bench for arm_inst_encoder: directed vector table, hand-written handshake
// sequences, and a randomized run against a queue-based reference model.
module tb_arm_inst_encoder;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 2;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int NADDR  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_sel;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic [4:0]        shamt;
    logic [1:0]        sh;
    logic [11:0]       imm12;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic [CW-1:0]     count;

    arm_inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COND(4'b1110)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm),
        .shamt(shamt), .sh(sh), .imm12(imm12),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [4:0]  shamt;
        logic [1:0]  sh;
        logic [11:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_inst [8];
    int          got_addr [8];
    int          n_got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input vec_t v);
        op_sel = v.op; rd = v.rd; rn = v.rn; rm = v.rm;
        shamt = v.shamt; sh = v.sh; imm12 = v.imm;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        step();
    endtask

    // Reference encoding built from the field positions with plain arithmetic.
    function automatic logic [31:0] ref_enc(input int op, input int d, input int n,
                                            input int m, input int s, input int t,
                                            input int imm);
        longint w;
        int     cmd;
        w = 64'hE000_0000;
        if (op >= 6) begin
            w += (1 << 26) + (1 << 24) + (1 << 23) + n * 65536 + d * 4096 + imm;
            if (op == 6) w += (1 << 20);
        end else begin
            case (op)
                0: cmd = 4;
                1: cmd = 2;
                2: cmd = 0;
                3: cmd = 12;
                4: cmd = 10;
                default: cmd = 13;
            endcase
            w += cmd * (1 << 21) + s * 128 + t * 32 + m;
            if (op == 4) w += (1 << 20);
            if (op != 5) w += n * 65536;
            if (op != 4) w += d * 4096;
        end
        return w[31:0];
    endfunction

    // Pushes tbl[start..n_push-1] while collecting every word popped.
    task automatic run_stream(input int start, input int n_push, input int n_pop, input int max_cyc);
        int k;
        int cyc;
        bit acc;
        k = start;
        cyc = 0;
        n_got = 0;
        while ((k < n_push || n_got < n_pop) && cyc < max_cyc) begin
            if (k < n_push) begin
                set_req(tbl[k]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready && n_got < 8) begin
                got_inst[n_got] = out_inst;
                got_addr[n_got] = int'(out_addr);
                n_got++;
            end
            if (acc) k++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_pop_count", n_got, n_pop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        logic [31:0] inst_q [$];
        int          addr_q [$];
        int          maddr;
        logic [31:0] last_i;
        int          last_a;
        bit          acc;
        bit          pop;

        tbl[0] = '{3'd0, 4'd1,  4'd2,  4'd3,  5'd0,  2'd0, 12'd0,     32'hE0821003};
        tbl[1] = '{3'd1, 4'd4,  4'd5,  4'd6,  5'd0,  2'd0, 12'd0,     32'hE0454006};
        tbl[2] = '{3'd4, 4'd7,  4'd1,  4'd2,  5'd0,  2'd0, 12'd0,     32'hE1510002};
        tbl[3] = '{3'd5, 4'd0,  4'd9,  4'd1,  5'd2,  2'd0, 12'd0,     32'hE1A00101};
        tbl[4] = '{3'd6, 4'd2,  4'd0,  4'd0,  5'd0,  2'd0, 12'd8,     32'hE5902008};
        tbl[5] = '{3'd7, 4'd2,  4'd0,  4'd0,  5'd0,  2'd0, 12'd4,     32'hE5802004};
        tbl[6] = '{3'd3, 4'd3,  4'd4,  4'd5,  5'd31, 2'd3, 12'd0,     32'hE1843FE5};
        tbl[7] = '{3'd2, 4'd15, 4'd14, 4'd13, 5'd1,  2'd2, 12'hFFF,   32'hE00EF0CD};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_req(tbl[0]);
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_count", count, 0);
        chk("reset_out_inst", out_inst, 0);
        chk("reset_out_addr", out_addr, 0);
        reset = 1'b0;
        step();

        // Directed vectors: one word at a time, latency and address checked.
        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i]);
            in_valid = 1'b1;
            chk("vec_pre_valid", out_valid, 0);
            step();
            in_valid = 1'b0;
            chk("vec_valid", out_valid, 1);
            chk("vec_inst", out_inst, tbl[i].exp);
            chk("vec_addr", out_addr, i % NADDR);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("vec_drained", out_valid, 0);
            chk("vec_last_inst", out_inst, tbl[i].exp);
        end

        // Backpressure: three requests, only two fit.
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            set_req(tbl[k]);
            in_valid = 1'b1;
            acc = in_ready;
            step();
            if (acc) k++;
        end
        chk("bp_accepts", k, 2);
        chk("bp_count", count, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head_stable", out_inst, tbl[0].exp);
        out_ready = 1'b1;
        run_stream(2, 3, 3, 20);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_order_inst", got_inst[i], tbl[i].exp);
            chk("bp_order_addr", got_addr[i], i);
        end

        // Address wrap with a 2-bit counter.
        do_reset();
        out_ready = 1'b1;
        run_stream(0, 5, 5, 30);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wrap_addr", got_addr[i], i % NADDR);
            chk("wrap_inst", got_inst[i], tbl[i].exp);
        end

        // Flush beats a simultaneous push and pop.
        do_reset();
        set_req(tbl[0]);
        in_valid = 1'b1;
        step();
        chk("flush_pre_count", count, 1);
        set_req(tbl[1]);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_no_pop", out_inst, 0);
        set_req(tbl[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("flush_next_addr", out_addr, 0);
        chk("flush_next_inst", out_inst, tbl[2].exp);

        // Async reset mid-stream with a popped word and one buffered.
        set_req(tbl[3]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ar_pre_count", count, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_inst", out_inst, 0);
        chk("ar_addr", out_addr, 0);
        chk("ar_in_ready", in_ready, 1);
        reset = 1'b0;
        step();

        // Randomized traffic against the queue model.
        maddr = 0;
        last_i = '0;
        last_a = 0;
        for (int c = 0; c < 500; c++) begin
            op_sel = 3'($urandom_range(0, 7));
            rd = 4'($urandom_range(0, 15));
            rn = 4'($urandom_range(0, 15));
            rm = 4'($urandom_range(0, 15));
            shamt = 5'($urandom_range(0, 31));
            sh = 2'($urandom_range(0, 3));
            imm12 = 12'($urandom_range(0, 4095));
            in_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush = ($urandom_range(0, 31) == 0);
            chk("rnd_count", count, inst_q.size());
            chk("rnd_in_ready", in_ready, (inst_q.size() < DEPTH));
            chk("rnd_out_valid", out_valid, (inst_q.size() != 0));
            chk("rnd_out_inst", out_inst, (inst_q.size() != 0) ? inst_q[0] : last_i);
            chk("rnd_out_addr", out_addr, (addr_q.size() != 0) ? addr_q[0] : last_a);
            if (flush) begin
                inst_q.delete();
                addr_q.delete();
                maddr = 0;
            end else begin
                pop = (inst_q.size() > 0) && out_ready;
                acc = in_valid && (inst_q.size() < DEPTH);
                if (pop) begin
                    last_i = inst_q.pop_front();
                    last_a = addr_q.pop_front();
                end
                if (acc) begin
                    inst_q.push_back(ref_enc(int'(op_sel), int'(rd), int'(rn), int'(rm),
                                             int'(shamt), int'(sh), int'(imm12)));
                    addr_q.push_back(maddr);
                    maddr = (maddr + 1) % NADDR;
                end
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_inst_encoder.md
Name: arm_inst_encoder

Overview:
- Encodes symbolic instruction requests into 32-bit ARM words using exactly the field layout the CPU's instruction decoder consumes.
- Buffers the encoded words in a small FIFO and tags each with a sequential instruction-memory word address.
- Used by the bench/boot loader to fill instruction memory before or alongside the single-cycle core.
- Valid/ready handshake on both sides.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
ADDR_W, 8, width of instruction-memory word address counter
COND, 4'b1110, condition field placed in bits 31:28 (AL)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of FIFO and address counter
in_valid  input  1  request present
in_ready  output  1  encoder can accept request
op_sel  input  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 CMP, 5 MOV(shift), 6 LDR, 7 STR
rd  input  4  destination / transfer register
rn  input  4  first source / base register
rm  input  4  second source register (DP only)
shamt  input  5  shift amount (DP only)
sh  input  2  shift type (DP only)
imm12  input  12  unsigned positive offset (LDR/STR only)
out_valid  output  1  encoded word available
out_ready  input  1  consumer takes word
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  word address tagged to out_inst
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: FIFO empty, write address counter 0, out_valid=0, out_inst=0, out_addr=0, count=0, in_ready=1. Reset mid-operation discards all buffered words immediately.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (count < DEPTH), from registered state only. No same-cycle pass-through when full, even if out_ready=1.
- Latency: word accepted at edge N is visible at the FIFO head from edge N+1. Encoding is combinational into the FIFO write data.
- Address tagging: accepted word gets the current address counter value; the counter then increments by 1 and wraps from 2^ADDR_W-1 to 0.
- Common fields: bits 31:28=COND; bit 25 (I)=0 for all ops.
- Data-processing (op_sel 0-5):
  - bits 27:26=00; bits 24:21=cmd (ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010, MOV 1101).
  - bit 20 (S)=1 only for CMP, else 0.
  - bits 19:16=rn, forced 0 for MOV.
  - bits 15:12=rd, forced 0 for CMP.
  - bits 11:7=shamt, 6:5=sh, bit 4=0, bits 3:0=rm.
- Memory (op_sel 6,7):
  - bits 27:26=01; bit 24 P=1, 23 U=1, 22 B=0, 21 W=0.
  - bit 20 L=1 for LDR, 0 for STR.
  - bits 19:16=rn, 15:12=rd, 11:0=imm12.
- Output:
  - out_valid = (count != 0).
  - out_inst/out_addr show the head entry; they hold stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready.
- Simultaneous push and pop: count unchanged, order preserved. Pop of the last entry with no push: out_valid falls the next cycle.
- Empty FIFO: out_inst and out_addr keep the last popped values (0 after reset).
- flush: at the edge it wins over a simultaneous push/pop. The FIFO empties, the counter returns to 0, and any request presented that cycle is dropped.

Test Plan:
- ADD rd=1 rn=2 rm=3 shamt=0 sh=0 -> out_inst=0xE0821003, out_addr=0, out_valid one cycle after accept.
- SUB rd=4 rn=5 rm=6 -> 0xE0454006; CMP rn=1 rm=2 rd=7 -> 0xE1510002 (Rd forced 0, S=1).
- MOV rd=0 rn=9 rm=1 shamt=2 sh=00 -> 0xE1A00101 (Rn forced 0).
- LDR rd=2 rn=0 imm12=8 -> 0xE5902008; then STR rd=2 rn=0 imm12=4 -> 0xE5802004 with out_addr=1.
- out_ready=0, push 3 requests -> in_ready drops after 2 accepts, count=2. Raise out_ready with in_valid held -> FIFO order kept, addresses 0,1,2.
- ADDR_W=2, push 5 words -> out_addr sequence 0,1,2,3,0. Assert flush with 1 word buffered -> count=0, next word gets out_addr=0. Async reset mid-stream -> outputs 0 immediately.
